// File: rtl/sram_pkg.sv
// Shared types, request-size constants and request checks for the SRAM sequencer.
package sram_pkg;

    // Sequencer states: one setup cycle and a stretched access phase per half-word.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } sram_state_e;

    // How many bytes a request moves on the 16-bit bus.
    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } access_size_e;

    // LSU access-size codes. Stores reuse the signed codes: sb=NB_B, sh=NB_H, sw=NB_W.
    localparam logic [2:0] NB_B  = 3'd0;
    localparam logic [2:0] NB_BU = 3'd1;
    localparam logic [2:0] NB_H  = 3'd2;
    localparam logic [2:0] NB_HU = 3'd3;
    localparam logic [2:0] NB_W  = 3'd4;

    function automatic access_size_e size_of(input logic [2:0] num_byte);
        if (num_byte == NB_W) begin
            return SZ_WORD;
        end else if ((num_byte == NB_H) || (num_byte == NB_HU)) begin
            return SZ_HALF;
        end
        return SZ_BYTE;
    endfunction

    // Codes 5..7 do not name any access size.
    function automatic logic is_illegal(input logic [2:0] num_byte);
        return num_byte > NB_W;
    endfunction

    // Half-words must sit on even addresses and words on multiples of four.
    function automatic logic is_misaligned(input logic [2:0] num_byte, input logic [1:0] addr_lo);
        case (num_byte)
            NB_H, NB_HU: return addr_lo[0];
            NB_W:        return |addr_lo;
            default:     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/sram_ctrl_if.sv
// LSU-side request/response bundle of the SRAM sequencer.
interface sram_ctrl_if;
    logic        i_req;
    logic        i_wren;
    logic [31:0] i_addr;
    logic [31:0] i_wdata;
    logic [2:0]  i_num_byte;
    logic [31:0] o_rdata;
    logic        o_ACK;
    logic        o_err;

    // The LSU issues the request and waits for the acknowledge.
    modport master (
        output i_req, i_wren, i_addr, i_wdata, i_num_byte,
        input  o_rdata, o_ACK, o_err
    );

    // The sequencer consumes the request and reports completion.
    modport slave (
        input  i_req, i_wren, i_addr, i_wdata, i_num_byte,
        output o_rdata, o_ACK, o_err
    );
endinterface

// File: rtl/sram_load_ext.sv
// Picks the addressed byte/half-word out of the collected SRAM data and extends it to 32 bits.
module sram_load_ext
    import sram_pkg::*;
(
    input  logic [31:0] raw_i,
    input  logic [2:0]  num_byte_i,
    input  logic        addr0_i,
    output logic [31:0] data_o
);

    logic [7:0] selByte;

    // Byte lane follows address bit 0; halves and words always start at the low half-word.
    always_comb begin
        selByte = addr0_i ? raw_i[15:8] : raw_i[7:0];
        data_o  = 32'h0;
        case (num_byte_i)
            NB_B:    data_o = {{24{selByte[7]}}, selByte};
            NB_BU:   data_o = {24'h0, selByte};
            NB_H:    data_o = {{16{raw_i[15]}}, raw_i[15:0]};
            NB_HU:   data_o = {16'h0, raw_i[15:0]};
            NB_W:    data_o = raw_i;
            default: data_o = 32'h0;
        endcase
    end

endmodule

// File: rtl/sram_ctrl.sv
// Sequencer between the LSU and a 16-bit asynchronous SRAM: splits each access
// into half-word bus cycles with a programmable strobe stretch and acks once.
module sram_ctrl
    import sram_pkg::*;
#(
    parameter int WAIT_CYCLES = 1,
    parameter int ADDR_W      = 18
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    sram_ctrl_if.slave        lsu,
    output logic [ADDR_W-1:0] o_SRAM_ADDR,
    output logic [15:0]       o_sram_dq,
    output logic              o_sram_dq_oe,
    input  logic [15:0]       i_sram_dq,
    output logic              o_SRAM_CE_N,
    output logic              o_SRAM_OE_N,
    output logic              o_SRAM_WE_N,
    output logic              o_SRAM_UB_N,
    output logic              o_SRAM_LB_N
);

    sram_state_e       state_q;
    logic              wren_q;
    logic [ADDR_W:0]   addr_q;
    logic [31:0]       wdata_q;
    logic [2:0]        nb_q;
    logic              half_q;
    logic [2:0]        waitCnt_q;
    logic [15:0]       buf0_q;
    logic [15:0]       buf1_q;
    logic [31:0]       rdata_q;
    logic              ack_q;
    logic              err_q;
    logic [ADDR_W-1:0] sramAddr_q;
    logic [15:0]       dq_q;
    logic              dqOe_q;
    logic              ceN_q;
    logic              oeN_q;
    logic              weN_q;
    logic              ubN_q;
    logic              lbN_q;

    logic              fromIdle;
    logic [ADDR_W:0]   curAddr;
    logic [31:0]       curWdata;
    access_size_e      curSize;
    logic              nextHalf;
    logic [ADDR_W-1:0] setupAddr;
    logic [15:0]       setupData;
    logic              setupUbN;
    logic              setupLbN;
    logic              reqBad;
    logic              accessLast;
    logic [15:0]       buf0_d;
    logic [15:0]       buf1_d;
    logic [31:0]       extData;
    logic [31:0]       rdata_d;
    logic              unusedAddrHi;

    // Address bits above the SRAM window wrap around and are never looked at.
    assign unusedAddrHi = ^lsu.i_addr[31:ADDR_W+1];

    // Bus values for the next SETUP cycle: first half straight from the live request,
    // second half of a word from the latched copy.
    always_comb begin
        fromIdle  = (state_q == IDLE);
        curAddr   = fromIdle ? lsu.i_addr[ADDR_W:0] : addr_q;
        curWdata  = fromIdle ? lsu.i_wdata : wdata_q;
        curSize   = size_of(fromIdle ? lsu.i_num_byte : nb_q);
        nextHalf  = ~fromIdle;
        setupAddr = curAddr[ADDR_W:1] + ADDR_W'(nextHalf);
        setupData = curWdata[15:0];
        setupUbN  = 1'b0;
        setupLbN  = 1'b0;
        case (curSize)
            SZ_BYTE: begin
                setupData = {curWdata[7:0], curWdata[7:0]};
                setupUbN  = ~curAddr[0];
                setupLbN  = curAddr[0];
            end
            SZ_WORD: setupData = nextHalf ? curWdata[31:16] : curWdata[15:0];
            default: setupData = curWdata[15:0];
        endcase
        reqBad = is_illegal(lsu.i_num_byte) || is_misaligned(lsu.i_num_byte, lsu.i_addr[1:0]);
    end

    // Capture SRAM read data on the final access cycle; the extender sees the freshly
    // captured half so the result can be registered on the same edge that enters DONE.
    always_comb begin
        accessLast = (state_q == ACCESS) && (waitCnt_q == 3'(WAIT_CYCLES));
        buf0_d     = buf0_q;
        buf1_d     = buf1_q;
        if (accessLast && !wren_q) begin
            if (half_q) begin
                buf1_d = i_sram_dq;
            end else begin
                buf0_d = i_sram_dq;
            end
        end
        rdata_d = wren_q ? 32'h0 : extData;
    end

    sram_load_ext u_load_ext (
        .raw_i      ({buf1_d, buf0_d}),
        .num_byte_i (nb_q),
        .addr0_i    (addr_q[0]),
        .data_o     (extData)
    );

    // Main sequencer; every bus pin and LSU response is a register updated here.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            wren_q     <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= 32'h0;
            nb_q       <= 3'd0;
            half_q     <= 1'b0;
            waitCnt_q  <= 3'd0;
            buf0_q     <= 16'h0;
            buf1_q     <= 16'h0;
            rdata_q    <= 32'h0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            sramAddr_q <= '0;
            dq_q       <= 16'h0;
            dqOe_q     <= 1'b0;
            ceN_q      <= 1'b1;
            oeN_q      <= 1'b1;
            weN_q      <= 1'b1;
            ubN_q      <= 1'b1;
            lbN_q      <= 1'b1;
        end else begin
            ack_q  <= 1'b0;
            buf0_q <= buf0_d;
            buf1_q <= buf1_d;
            case (state_q)
                IDLE: begin
                    err_q <= 1'b0;
                    if (lsu.i_req) begin
                        wren_q    <= lsu.i_wren;
                        addr_q    <= lsu.i_addr[ADDR_W:0];
                        wdata_q   <= lsu.i_wdata;
                        nb_q      <= lsu.i_num_byte;
                        half_q    <= 1'b0;
                        waitCnt_q <= 3'd0;
                        if (reqBad) begin
                            state_q <= DONE;
                            ack_q   <= 1'b1;
                            err_q   <= 1'b1;
                            rdata_q <= 32'h0;
                        end else begin
                            state_q    <= SETUP;
                            sramAddr_q <= setupAddr;
                            dq_q       <= setupData;
                            dqOe_q     <= lsu.i_wren;
                            ceN_q      <= 1'b0;
                            oeN_q      <= lsu.i_wren;
                            ubN_q      <= setupUbN;
                            lbN_q      <= setupLbN;
                        end
                    end
                end
                SETUP: begin
                    state_q   <= ACCESS;
                    waitCnt_q <= 3'd0;
                    weN_q     <= ~wren_q;
                    oeN_q     <= wren_q;
                end
                ACCESS: begin
                    if (accessLast) begin
                        waitCnt_q <= 3'd0;
                        if ((size_of(nb_q) == SZ_WORD) && !half_q) begin
                            state_q    <= SETUP;
                            half_q     <= 1'b1;
                            sramAddr_q <= setupAddr;
                            dq_q       <= setupData;
                            weN_q      <= 1'b1;
                            oeN_q      <= 1'b1;
                        end else begin
                            state_q <= DONE;
                            ack_q   <= 1'b1;
                            rdata_q <= rdata_d;
                            dqOe_q  <= 1'b0;
                            ceN_q   <= 1'b1;
                            oeN_q   <= 1'b1;
                            weN_q   <= 1'b1;
                            ubN_q   <= 1'b1;
                            lbN_q   <= 1'b1;
                        end
                    end else begin
                        waitCnt_q <= waitCnt_q + 3'd1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    err_q   <= 1'b0;
                    half_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign lsu.o_rdata   = rdata_q;
    assign lsu.o_ACK     = ack_q;
    assign lsu.o_err     = err_q;
    assign o_SRAM_ADDR   = sramAddr_q;
    assign o_sram_dq     = dq_q;
    assign o_sram_dq_oe  = dqOe_q;
    assign o_SRAM_CE_N   = ceN_q;
    assign o_SRAM_OE_N   = oeN_q;
    assign o_SRAM_WE_N   = weN_q;
    assign o_SRAM_UB_N   = ubN_q;
    assign o_SRAM_LB_N   = lbN_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: three sequencers with different wait counts, each wired to its
// own behavioural SRAM, checked against a byte-addressed memory model.
module tb_sram_ctrl;
    import sram_pkg::*;

    localparam int NDUT = 3;

    logic        clk = 1'b0;
    logic        rstN;
    logic        req;
    logic        wren;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  nb;
    int          sel;

    logic [31:0] rdataV [NDUT];
    logic        ackV   [NDUT];
    logic        errV   [NDUT];
    logic [17:0] sAddrV [NDUT];
    logic [15:0] dqOutV [NDUT];
    logic [15:0] dqInV  [NDUT];
    logic        dqOeV  [NDUT];
    logic        ceV    [NDUT];
    logic        oeV    [NDUT];
    logic        weV    [NDUT];
    logic        ubV    [NDUT];
    logic        lbV    [NDUT];

    logic [15:0] sramMem [NDUT][262144];
    logic [7:0]  refMem  [NDUT][524288];

    int          checks = 0;
    int          errors = 0;
    int          lastLat;
    logic [31:0] lastData;
    logic        lastErr;

    always #5 clk = ~clk;

    // One sequencer per wait count; only the selected one sees the request.
    for (genvar g = 0; g < NDUT; g++) begin : gDut
        localparam int W = (g == 0) ? 0 : ((g == 1) ? 1 : 3);
        sram_ctrl_if lsu ();
        assign lsu.i_req      = req && (sel == g);
        assign lsu.i_wren     = wren;
        assign lsu.i_addr     = addr;
        assign lsu.i_wdata    = wdata;
        assign lsu.i_num_byte = nb;
        assign rdataV[g]      = lsu.o_rdata;
        assign ackV[g]        = lsu.o_ACK;
        assign errV[g]        = lsu.o_err;
        assign dqInV[g]       = (!ceV[g] && !oeV[g] && !dqOeV[g]) ? sramMem[g][sAddrV[g]] : 16'h5A5A;

        sram_ctrl #(.WAIT_CYCLES(W), .ADDR_W(18)) dut (
            .i_clk        (clk),
            .i_rst_n      (rstN),
            .lsu          (lsu),
            .o_SRAM_ADDR  (sAddrV[g]),
            .o_sram_dq    (dqOutV[g]),
            .o_sram_dq_oe (dqOeV[g]),
            .i_sram_dq    (dqInV[g]),
            .o_SRAM_CE_N  (ceV[g]),
            .o_SRAM_OE_N  (oeV[g]),
            .o_SRAM_WE_N  (weV[g]),
            .o_SRAM_UB_N  (ubV[g]),
            .o_SRAM_LB_N  (lbV[g])
        );
    end

    // Behavioural SRAMs: a write lands mid-cycle on whichever byte lanes are enabled.
    always @(negedge clk) begin
        for (int g = 0; g < NDUT; g++) begin
            if (!ceV[g] && !weV[g] && dqOeV[g]) begin
                if (!lbV[g]) sramMem[g][sAddrV[g]][7:0]  <= dqOutV[g][7:0];
                if (!ubV[g]) sramMem[g][sAddrV[g]][15:8] <= dqOutV[g][15:8];
            end
        end
    end

    function automatic int waitOf(input int g);
        return (g == 0) ? 0 : ((g == 1) ? 1 : 3);
    endfunction

    function automatic int sizeBytes(input logic [2:0] n);
        if (n == 3'd4) return 4;
        if (n == 3'd2 || n == 3'd3) return 2;
        return 1;
    endfunction

    function automatic logic expectErr(input logic [2:0] n, input logic [31:0] a);
        int sz;
        sz = sizeBytes(n);
        return (n > 3'd4) || (sz == 2 && a[0]) || (sz == 4 && a[1:0] != 2'b00);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one request on sequencer g, watch the bus until the acknowledge, then
    // compare everything seen against what the memory model says should happen.
    task automatic applyStimulus(input int g, input logic w, input logic [31:0] a,
                                 input logic [31:0] d, input logic [2:0] n, input int dropAfter);
        int          lat, ceLow, weLow, oeCyc, wt, sz, expLat, expWe;
        logic        ubSeen, lbSeen, expE, expUb, expLb;
        logic [5:0]  doneBus;
        logic [31:0] v, expData, gotData;
        logic        gotErr;
        @(posedge clk); #1;
        checkOutput("ackIdle", 32'(ackV[g]), 32'd0);
        sel = g; req = 1'b1; wren = w; addr = a; wdata = d; nb = n;
        lat = 0; ceLow = 0; weLow = 0; oeCyc = 0; ubSeen = 0; lbSeen = 0;
        doneBus = 6'h0; gotData = 32'h0; gotErr = 1'b0;
        for (int c = 1; c <= 60 && lat == 0; c++) begin
            @(posedge clk); #1;
            if (dropAfter != 0 && c > dropAfter) req = 1'b0;
            if (ackV[g]) begin
                lat     = c;
                gotData = rdataV[g];
                gotErr  = errV[g];
                doneBus = {ceV[g], oeV[g], weV[g], ubV[g], lbV[g], dqOeV[g]};
            end else begin
                if (!ceV[g]) ceLow++;
                if (!weV[g]) weLow++;
                if (dqOeV[g]) oeCyc++;
                if (!ceV[g] && !ubV[g]) ubSeen = 1'b1;
                if (!ceV[g] && !lbV[g]) lbSeen = 1'b1;
            end
        end
        req = 1'b0;

        wt   = waitOf(g);
        sz   = sizeBytes(n);
        expE = expectErr(n, a);
        expLat = expE ? 1 : ((sz == 4) ? 2 * (wt + 2) + 1 : 3 + wt);
        v = 32'h0;
        for (int i = 0; i < sz; i++) v[8*i +: 8] = refMem[g][(a[18:0] + 19'(i))];
        case (n)
            3'd0:    expData = {{24{v[7]}}, v[7:0]};
            3'd1:    expData = {24'h0, v[7:0]};
            3'd2:    expData = {{16{v[15]}}, v[15:0]};
            3'd3:    expData = {16'h0, v[15:0]};
            default: expData = v;
        endcase
        if (expE || w) expData = 32'h0;
        if (w && !expE) begin
            for (int i = 0; i < sz; i++) refMem[g][(a[18:0] + 19'(i))] = d[8*i +: 8];
        end
        expWe = (w && !expE) ? ((sz == 4) ? 2 : 1) * (wt + 1) : 0;
        expUb = !expE && (sz > 1 || a[0]);
        expLb = !expE && (sz > 1 || !a[0]);

        checkOutput("latency", 32'(lat), 32'(expLat));
        checkOutput("err", 32'(gotErr), 32'(expE));
        checkOutput("rdata", gotData, expData);
        checkOutput("ceLowCycles", 32'(ceLow), expE ? 32'd0 : 32'(expLat - 1));
        checkOutput("weLowCycles", 32'(weLow), 32'(expWe));
        checkOutput("dqOeCycles", 32'(oeCyc), (w && !expE) ? 32'(expLat - 1) : 32'd0);
        checkOutput("lanes", {30'h0, ubSeen, lbSeen}, {30'h0, expUb, expLb});
        checkOutput("doneBusIdle", {26'h0, doneBus}, 32'h3E);
        lastLat = lat; lastData = gotData; lastErr = gotErr;
    endtask

    // Abort a store in its access phase with reset and confirm the bus drops at once.
    task automatic resetDuringStore();
        int ackSeen;
        @(posedge clk); #1;
        sel = 1; req = 1'b1; wren = 1'b1; addr = 32'h0000_0300; wdata = 32'h1234_5678; nb = 3'd4;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checkOutput("rstPreWe", 32'(weV[1]), 32'd0);
        #2 rstN = 1'b0;
        #1;
        checkOutput("rstAsyncBus", {26'h0, ceV[1], oeV[1], weV[1], ubV[1], lbV[1], dqOeV[1]}, 32'h3E);
        req = 1'b0;
        ackSeen = 0;
        repeat (2) begin
            @(posedge clk); #1;
            if (ackV[1]) ackSeen++;
        end
        @(negedge clk) rstN = 1'b1;
        repeat (8) begin
            @(posedge clk); #1;
            if (ackV[1]) ackSeen++;
        end
        checkOutput("rstNoAck", 32'(ackSeen), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "[TB] watchdog");
    end

    // Directed scenarios first, then randomized traffic on every wait count.
    initial begin
        logic [31:0] r, a;
        rstN = 1'b0; req = 1'b0; wren = 1'b0; addr = 32'h0; wdata = 32'h0; nb = 3'd0; sel = 0;
        repeat (3) @(posedge clk);
        #1;
        for (int g = 0; g < NDUT; g++) begin
            checkOutput("resetBus", {26'h0, ceV[g], oeV[g], weV[g], ubV[g], lbV[g], dqOeV[g]}, 32'h3E);
            checkOutput("resetResp", {rdataV[g][29:0], ackV[g], errV[g]}, 32'h0);
            checkOutput("resetAddr", 32'(sAddrV[g]), 32'h0);
        end
        @(negedge clk) rstN = 1'b1;

        $display("[TB] directed tests, WAIT_CYCLES=1");
        applyStimulus(1, 1'b1, 32'h0000_0100, 32'h0000_80FF, 3'd2, 0);
        applyStimulus(1, 1'b0, 32'h0000_0101, 32'h0, 3'd0, 0);
        checkOutput("lbConst", lastData, 32'hFFFF_FF80);
        checkOutput("lbLat", 32'(lastLat), 32'd4);
        applyStimulus(1, 1'b0, 32'h0000_0101, 32'h0, 3'd1, 0);
        checkOutput("lbuConst", lastData, 32'h0000_0080);
        applyStimulus(1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 3'd4, 0);
        checkOutput("swLat", 32'(lastLat), 32'd7);
        checkOutput("swHalf0", 32'(sramMem[1][18'h080]), 32'h0000_BEEF);
        checkOutput("swHalf1", 32'(sramMem[1][18'h081]), 32'h0000_DEAD);
        applyStimulus(1, 1'b0, 32'h0000_0100, 32'h0, 3'd4, 0);
        checkOutput("lwConst", lastData, 32'hDEAD_BEEF);
        applyStimulus(1, 1'b0, 32'h0000_0102, 32'h0, 3'd2, 0);
        checkOutput("lhConst", lastData, 32'hFFFF_DEAD);
        applyStimulus(1, 1'b1, 32'h0000_0103, 32'h0000_4444, 3'd2, 0);
        checkOutput("shMisErr", 32'(lastErr), 32'd1);
        applyStimulus(1, 1'b1, 32'h0000_0100, 32'h5555_5555, 3'd6, 0);
        checkOutput("nb6Err", 32'(lastErr), 32'd1);
        checkOutput("errMemUntouched", 32'(sramMem[1][18'h081]), 32'h0000_DEAD);

        $display("[TB] reset during store access");
        resetDuringStore();
        applyStimulus(1, 1'b0, 32'h0000_0100, 32'h0, 3'd4, 0);
        checkOutput("lwAfterReset", lastData, 32'hDEAD_BEEF);

        $display("[TB] latency on WAIT_CYCLES=0 and WAIT_CYCLES=3");
        applyStimulus(0, 1'b1, 32'h0000_0100, 32'h0000_80FF, 3'd2, 0);
        applyStimulus(0, 1'b0, 32'h0000_0101, 32'h0, 3'd1, 0);
        checkOutput("w0LbuLat", 32'(lastLat), 32'd3);
        applyStimulus(2, 1'b1, 32'h0000_0100, 32'hCAFE_F00D, 3'd4, 0);
        applyStimulus(2, 1'b0, 32'h0000_0100, 32'h0, 3'd4, 2);
        checkOutput("w3LwLat", 32'(lastLat), 32'd11);
        checkOutput("w3LwData", lastData, 32'hCAFE_F00D);

        $display("[TB] randomized traffic");
        for (int g = 0; g < NDUT; g++) begin
            for (int i = 0; i < 8; i++) begin
                r = $urandom();
                a = {r[31:19], 19'h200 + 19'(4 * i)};
                applyStimulus(g, 1'b1, a, $urandom(), 3'd4, 0);
            end
            for (int i = 0; i < 40; i++) begin
                r = $urandom();
                a = {r[31:19], 19'h200 + 19'($urandom_range(0, 31))};
                nb = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 4));
                applyStimulus(g, 1'($urandom_range(0, 1)), a, $urandom(), nb, 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_ctrl.md
Name: sram_ctrl

Overview:
- Multi-cycle sequencer between the core's LSU and the off-chip 16-bit asynchronous SRAM (256K x 16).
- Accepts one load/store request at a time and breaks each 32-bit access into half-word bus cycles.
- Drives SRAM strobes with a programmable wait count and returns sign/zero-extended load data.
- Pulses o_ACK; the control unit holds en_pc low on SRAM loads/stores until o_ACK.

Parameters:
- WAIT_CYCLES, 1, extra strobe-active cycles per half-word bus cycle (0..7).
- ADDR_W, 18, SRAM half-word address width.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_req  in  1  LSU access request (mem_read|mem_wren while in_sram); held until o_ACK
- i_wren  in  1  1=store, 0=load
- i_addr  in  32  byte address
- i_wdata  in  32  store data
- i_num_byte  in  3  0 lb, 1 lbu, 2 lh, 3 lhu, 4 lw/sw; sb=0, sh=2
- o_rdata  out  32  extended load data, valid while o_ACK=1
- o_ACK  out  1  one-cycle completion pulse
- o_err  out  1  with o_ACK: misaligned or illegal i_num_byte
- o_SRAM_ADDR  out  ADDR_W  half-word address
- o_sram_dq  out  16  write data
- o_sram_dq_oe  out  1  tristate enable for DQ
- i_sram_dq  in  16  read data
- o_SRAM_CE_N, o_SRAM_OE_N, o_SRAM_WE_N, o_SRAM_UB_N, o_SRAM_LB_N  out  1 each  active-low strobes

Behaviour:
- Reset (async, i_rst_n=0):
  - state IDLE; all *_N outputs 1; o_sram_dq_oe=0; o_ACK=0; o_err=0; o_rdata=0; o_SRAM_ADDR=0; wait counter and half index 0.
  - Reset mid-transaction aborts immediately; the partial write is not retried.
- States: IDLE, SETUP, ACCESS, DONE.
- IDLE:
  - On i_req=1, latch i_wren, i_addr, i_wdata and i_num_byte.
  - Check alignment: lh/lhu/sh need addr[0]=0; lw/sw need addr[1:0]=0; i_num_byte 5..7 is illegal.
  - Error: go to DONE with o_err=1, o_rdata=0, and no SRAM strobes.
  - Otherwise go to SETUP with half=0.
- SETUP (1 cycle):
  - o_SRAM_ADDR = addr[18:1] + half.
  - CE_N=0. Loads: OE_N=0. Stores: o_sram_dq_oe=1.
  - Lanes: byte uses addr[0]=0 -> LB_N=0, addr[0]=1 -> UB_N=0; half/word use both.
  - Write data: byte = {wdata[7:0],wdata[7:0]}; half = wdata[15:0]; word half0 = wdata[15:0], half1 = wdata[31:16].
- ACCESS (WAIT_CYCLES+1 cycles):
  - Stores: WE_N=0. Address, data and lanes stay stable.
  - Loads: sample i_sram_dq on the last ACCESS cycle into the half-0 or half-1 buffer.
  - Exit: word with half=0 -> SETUP with half=1; otherwise -> DONE.
  - WE_N and OE_N return to 1 on the SETUP re-entry; CE_N stays 0 between halves.
- DONE (1 cycle):
  - o_ACK=1; all strobes inactive; o_rdata valid (registered).
  - Next state IDLE. The PC advances on this edge, so the following cycle carries a new instruction.
- Latency: from the request cycle (T0, in IDLE), o_ACK is high in cycle:
  - byte/half: T0+3+WAIT_CYCLES.
  - word: T0+2*(WAIT_CYCLES+2)+1.
  - error: T0+1.
  - Back-to-back requests: the next request is accepted in the IDLE cycle right after DONE.
- Extension:
  - lb: sign-extend the selected byte; lbu: zero-extend it.
  - lh: sign-extend buf0; lhu: zero-extend buf0.
  - lw: {buf1,buf0}.
  - Stores return o_rdata=0.
- i_req deasserting mid-transaction: the transaction still completes and o_ACK still pulses. i_req changes after IDLE are ignored.
- Address bits above 18 are ignored (wrap-around within 512 KiB).

Decomposition:
- Package sram_pkg holds:
  - state enum (IDLE, SETUP, ACCESS, DONE).
  - num_byte constants NB_B=0, NB_BU=1, NB_H=2, NB_HU=3, NB_W=4.
  - function is_misaligned(num_byte, addr[1:0]).
- Sub-module sram_load_ext: combinational extension of {buf1,buf0}, num_byte and addr[0] to a 32-bit result, registered in the top.

Test Plan:
- sw addr=0x100, wdata=0xDEADBEEF, WAIT_CYCLES=1 -> SRAM addr 0x080 gets 0xBEEF and 0x081 gets 0xDEAD; WE_N low 2 cycles per half; o_ACK in cycle T0+7, o_err=0.
- lb addr=0x101 with SRAM[0x080]=0x80FF -> UB_N=0, LB_N=1; o_rdata=0xFFFFFF80. lbu at the same address -> 0x00000080. Both ACK at T0+4.
- sh addr=0x103 -> o_ACK and o_err at T0+1; CE_N, WE_N never low; SRAM unchanged. i_num_byte=6 -> same.
- lw addr=0x100 right after the sw (request held in the IDLE cycle after DONE) -> o_rdata=0xDEADBEEF. lh addr=0x102 -> 0xFFFFDEAD.
- Reset asserted during ACCESS of a sw -> all strobes 1 and dq_oe 0 without waiting for a clock; o_ACK never pulses; after release, IDLE accepts a new lw normally.
- WAIT_CYCLES=0 lbu and WAIT_CYCLES=3 lw -> ACK at T0+3 and T0+11 respectively; i_req dropped after T0+2 still yields an ACK.
